// File: rtl/facedet_pkg.sv
// Shared face-detection definitions: default integral-image geometry, the
// integral generator state encoding and the detector core thresholds.
package facedet_pkg;

  localparam int DEF_MAX_WIDTH = 768;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_SUM_W     = 32;
  localparam int DEF_ADDR_W    = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ii_state_e;

  localparam int STAGE0_THRESH = 822689;
  localparam int STAGE1_THRESH = 6956;
  localparam int STAGE2_THRESH = 9498;
  localparam int WINDOW_SIZE   = 24;

  // A tile side is legal when it is non-zero and fits the line buffer.
  function automatic logic size_ok(input logic [15:0] v, input int max_v);
    return (v != '0) && (32'(v) <= max_v);
  endfunction

endpackage

// File: rtl/ii_line_buffer.sv
// One-row store of the previous row's integral words: asynchronous read,
// synchronous write, no reset (contents are don't-care until row 0 rewrites them).
module ii_line_buffer #(
  parameter int DEPTH  = 768,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area-table builder: raster pixels in, (address, ii) words out.
// Build option INTEGRAL_SAT_EN: clamp every addition and expose a sticky sat_flag.
module integral_image_gen
  import facedet_pkg::*;
#(
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [SUM_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
`ifdef INTEGRAL_SAT_EN
  output logic              sat_flag,
`endif
  output logic              cfg_err
);

  localparam int IDX_W = $clog2(MAX_WIDTH);
  localparam int CNT_W = 16;

  ii_state_e         state_q, state_d;
  logic [CNT_W-1:0]  w_q, w_d, h_q, h_d;
  logic [IDX_W-1:0]  x_q, x_d, y_q, y_d;
  logic [SUM_W-1:0]  s_q, s_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [SUM_W-1:0]  out_data_q, out_data_d;
  logic              cfg_err_q, cfg_err_d;

  logic              accept;
  logic              x_last, y_last;
  logic [SUM_W-1:0]  lb_rdata, prev_word, s_new, word;

`ifdef INTEGRAL_SAT_EN
  logic              sat_q, sat_d;
  logic [SUM_W:0]    s_full, w_full;
  logic              s_clamp, w_clamp;
`endif

  assign pix_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign x_last    = ({{(CNT_W-IDX_W){1'b0}}, x_q} == (w_q - 16'd1));
  assign y_last    = ({{(CNT_W-IDX_W){1'b0}}, y_q} == (h_q - 16'd1));

  ii_line_buffer #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (SUM_W),
    .IDX_W  (IDX_W)
  ) u_line_buffer (
    .clk     (clk),
    .rd_idx  (x_q),
    .rd_data (lb_rdata),
    .wr_en   (accept),
    .wr_idx  (x_q),
    .wr_data (word)
  );

  // Row 0 must ignore the buffer: it may hold a previous or aborted tile.
  always_comb begin
    prev_word = (y_q == '0) ? '0 : lb_rdata;
`ifdef INTEGRAL_SAT_EN
    s_full  = {1'b0, s_q} + {{(SUM_W+1-PIX_W){1'b0}}, pix_data};
    s_clamp = s_full[SUM_W];
    s_new   = s_clamp ? '1 : s_full[SUM_W-1:0];
    w_full  = {1'b0, prev_word} + {1'b0, s_new};
    w_clamp = w_full[SUM_W];
    word    = w_clamp ? '1 : w_full[SUM_W-1:0];
`else
    s_new   = s_q + {{(SUM_W-PIX_W){1'b0}}, pix_data};
    word    = prev_word + s_new;
`endif
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    x_d         = x_q;
    y_d         = y_q;
    s_d         = s_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    cfg_err_d   = 1'b0;
`ifdef INTEGRAL_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok(width, MAX_WIDTH) && size_ok(height, MAX_WIDTH)) begin
            w_d     = width;
            h_d     = height;
            x_d     = '0;
            y_d     = '0;
            s_d     = '0;
            addr_d  = '0;
            state_d = RUN;
`ifdef INTEGRAL_SAT_EN
            sat_d   = 1'b0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
        // A new accept reloads the output register in the same cycle it drains.
        if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = addr_q;
          out_data_d  = word;
          addr_d      = addr_q + ADDR_W'(1);
`ifdef INTEGRAL_SAT_EN
          sat_d       = sat_q | s_clamp | w_clamp;
`endif
          if (x_last) begin
            x_d = '0;
            s_d = '0;
            y_d = y_q + IDX_W'(1);
            if (y_last) begin
              state_d = DRAIN;
            end
          end else begin
            x_d = x_q + IDX_W'(1);
            s_d = s_new;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
`ifdef INTEGRAL_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
`ifdef INTEGRAL_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
`ifdef INTEGRAL_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule
